aurora_rx_guard: RTL and testbench



---
 rtl/aurora_rx_guard.sv | 182 ++++++++++++++++++
 tb/tb_aurora_rx_guard.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aurora_rx_guard.sv
// aurora_rx_guard
// Registers the Aurora RX AXI-Stream on its way into the RX FIFO. Aurora has
// no backpressure, so a beat that arrives when the output register cannot take
// it, or while the link is down, is lost. This block records each lost beat and
// keeps the downstream framing intact. A frame that is cut short is closed with
// a synthetic terminator beat (tlast=1, terr=1), and the rest of that frame is
// discarded on the input side.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   channel_up        Aurora link status
//   i_rx_t*           Aurora RX stream (tdata/tkeep/tvalid/tlast, no tready)
//   o_rx_t*           registered stream to the RX FIFO; o_rx_terr marks a terminator
//   o_rx_tready       RX FIFO ready
//   loss_data         one-cycle pulse per dropped input beat
//   loss_frame        one-cycle pulse per frame declared corrupted
//   loss_cnt          saturating count of loss_frame pulses
module aurora_rx_guard #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              channel_up,
  output logic              loss_data,
  output logic              loss_frame,
  output logic [CNT_W-1:0]  loss_cnt,
  input  logic [DATA_W-1:0] i_rx_tdata,
  input  logic [KEEP_W-1:0] i_rx_tkeep,
  input  logic              i_rx_tvalid,
  input  logic              i_rx_tlast,
  output logic [DATA_W-1:0] o_rx_tdata,
  output logic [KEEP_W-1:0] o_rx_tkeep,
  output logic              o_rx_tvalid,
  output logic              o_rx_tlast,
  output logic              o_rx_terr,
  input  logic              o_rx_tready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no downstream frame open
    PASS    = 2'd1,  // downstream frame open, beats flowing
    CLOSE   = 2'd2,  // waiting for room to emit the terminator
    DISCARD = 2'd3   // dropping the remainder of a broken input frame
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_pending;
  logic                w_pending_nxt;
  logic                w_free;
  logic                w_load_in;
  logic                w_load_term;
  logic                w_lframe;
  logic                w_ldata;

  logic [DATA_W-1:0]   r_tdata;
  logic [KEEP_W-1:0]   r_tkeep;
  logic                r_tvalid;
  logic                r_tlast;
  logic                r_terr;
  logic                r_loss_data;
  logic                r_loss_frame;
  logic [CNT_W-1:0]    r_loss_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_free = !r_tvalid | o_rx_tready;

  // Next-state and load decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_load_in     = 1'b0;
    w_load_term   = 1'b0;
    w_lframe      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_rx_tvalid) begin
          if (channel_up && w_free) begin
            w_load_in = 1'b1;
            if (!i_rx_tlast) w_state_nxt = PASS;
          end else begin
            // First beat of a frame lost: nothing downstream to close.
            w_lframe = 1'b1;
            if (!i_rx_tlast) w_state_nxt = DISCARD;
          end
        end
      end
      PASS: begin
        if (!channel_up) begin
          // Link loss ends the input frame too, so nothing left to discard.
          w_lframe      = 1'b1;
          w_pending_nxt = 1'b0;
          w_state_nxt   = CLOSE;
        end else if (i_rx_tvalid && !w_free) begin
          w_lframe      = 1'b1;
          w_pending_nxt = !i_rx_tlast;
          w_state_nxt   = CLOSE;
        end else if (i_rx_tvalid) begin
          w_load_in = 1'b1;
          if (i_rx_tlast) w_state_nxt = IDLE;
        end
      end
      CLOSE: begin
        // pending tracks whether the input side is still inside a frame
        // that must be discarded once the terminator has gone out.
        if (i_rx_tvalid) w_pending_nxt = !i_rx_tlast;
        if (!channel_up) w_pending_nxt = 1'b0;
        if (w_free) begin
          w_load_term = 1'b1;
          w_state_nxt = w_pending_nxt ? DISCARD : IDLE;
        end
      end
      DISCARD: begin
        if ((i_rx_tvalid && i_rx_tlast) || !channel_up) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_ldata = i_rx_tvalid & !w_load_in;
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pending    <= 1'b0;
      r_loss_data  <= 1'b0;
      r_loss_frame <= 1'b0;
      r_loss_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pending    <= w_pending_nxt;
      r_loss_data  <= w_ldata;
      r_loss_frame <= w_lframe;
      if (w_lframe) r_loss_cnt <= sat_inc(r_loss_cnt);
    end
  end

  // Output register: loads an input beat or the terminator, holds while
  // stalled, and clears fully once unloaded with nothing new behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_terr   <= 1'b0;
    end else if (w_load_in) begin
      r_tdata  <= i_rx_tdata;
      r_tkeep  <= i_rx_tkeep;
      r_tvalid <= 1'b1;
      r_tlast  <= i_rx_tlast;
      r_terr   <= 1'b0;
    end else if (w_load_term) begin
      r_tdata  <= '0;
      r_tkeep  <= KEEP_W'(1);
      r_tvalid <= 1'b1;
      r_tlast  <= 1'b1;
      r_terr   <= 1'b1;
    end else if (o_rx_tready) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_terr   <= 1'b0;
    end
  end

  assign o_rx_tdata  = r_tdata;
  assign o_rx_tkeep  = r_tkeep;
  assign o_rx_tvalid = r_tvalid;
  assign o_rx_tlast  = r_tlast;
  assign o_rx_terr   = r_terr;
  assign loss_data   = r_loss_data;
  assign loss_frame  = r_loss_frame;
  assign loss_cnt    = r_loss_cnt;

endmodule

// File: tb/tb_aurora_rx_guard.sv
module tb_aurora_rx_guard;

  localparam int DATA_W = 16;
  localparam int KEEP_W = 2;
  localparam int CNT_W  = 2;
  localparam int AW     = 1 + DATA_W + KEEP_W + 1 + 1 + 1 + 1 + CNT_W;

  logic              clk;
  logic              rst;
  logic              channel_up;
  logic              loss_data;
  logic              loss_frame;
  logic [CNT_W-1:0]  loss_cnt;
  logic [DATA_W-1:0] i_rx_tdata;
  logic [KEEP_W-1:0] i_rx_tkeep;
  logic              i_rx_tvalid;
  logic              i_rx_tlast;
  logic [DATA_W-1:0] o_rx_tdata;
  logic [KEEP_W-1:0] o_rx_tkeep;
  logic              o_rx_tvalid;
  logic              o_rx_tlast;
  logic              o_rx_terr;
  logic              o_rx_tready;

  aurora_rx_guard #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .channel_up(channel_up),
    .loss_data(loss_data), .loss_frame(loss_frame), .loss_cnt(loss_cnt),
    .i_rx_tdata(i_rx_tdata), .i_rx_tkeep(i_rx_tkeep),
    .i_rx_tvalid(i_rx_tvalid), .i_rx_tlast(i_rx_tlast),
    .o_rx_tdata(o_rx_tdata), .o_rx_tkeep(o_rx_tkeep),
    .o_rx_tvalid(o_rx_tvalid), .o_rx_tlast(o_rx_tlast),
    .o_rx_terr(o_rx_terr), .o_rx_tready(o_rx_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {tvalid, tdata, tkeep, tlast, terr, loss_data, loss_frame, loss_cnt}
  wire [AW-1:0] w_act = {o_rx_tvalid, o_rx_tdata, o_rx_tkeep, o_rx_tlast,
                         o_rx_terr, loss_data, loss_frame, loss_cnt};

  typedef struct {
    bit                rs;
    bit                v;
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    bit                l;
    bit                cu;
    bit                rdy;
    logic [AW-1:0]     want;
  } vec_t;

  vec_t          vecs[$];
  logic [AW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [AW-1:0] pack(bit ev, logic [DATA_W-1:0] ed,
      logic [KEEP_W-1:0] ek, bit el, bit ee, bit eld, bit elf,
      logic [CNT_W-1:0] ecnt);
    return {ev, ed, ek, el, ee, eld, elf, ecnt};
  endfunction

  function automatic void add(bit rs, bit v, logic [DATA_W-1:0] d,
      logic [KEEP_W-1:0] k, bit l, bit cu, bit rdy,
      bit ev, logic [DATA_W-1:0] ed, logic [KEEP_W-1:0] ek, bit el, bit ee,
      bit eld, bit elf, logic [CNT_W-1:0] ecnt);
    vec_t t;
    t.rs = rs; t.v = v; t.d = d; t.k = k; t.l = l; t.cu = cu; t.rdy = rdy;
    t.want = pack(ev, ed, ek, el, ee, eld, elf, ecnt);
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [AW-1:0] want);
    n_checks++;
    if (w_act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, w_act, want);
    end
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d,
      input logic [KEEP_W-1:0] k, input bit l, input bit cu, input bit rdy);
    i_rx_tvalid = v;
    i_rx_tdata  = d;
    i_rx_tkeep  = k;
    i_rx_tlast  = l;
    channel_up  = cu;
    o_rx_tready = rdy;
  endtask

  initial begin
    // Scenario: clean 3-beat frame
    add(0,1,16'hA000,2'b11,0,1,1, 1,16'hA000,2'b11,0,0, 0,0,0);
    add(0,1,16'hA001,2'b11,0,1,1, 1,16'hA001,2'b11,0,0, 0,0,0);
    add(0,1,16'hA002,2'b10,1,1,1, 1,16'hA002,2'b10,1,0, 0,0,0);
    add(0,0,16'h0000,2'b00,0,1,1, 0,16'h0000,2'b00,0,0, 0,0,0);
    // Scenario: overflow on beat 2 of a 5-beat frame, then a clean frame
    add(0,1,16'hB001,2'b11,0,1,1, 1,16'hB001,2'b11,0,0, 0,0,0);
    add(0,1,16'hB002,2'b11,0,1,0, 1,16'hB001,2'b11,0,0, 1,1,1);
    add(0,1,16'hB003,2'b11,0,1,0, 1,16'hB001,2'b11,0,0, 1,0,1);
    add(0,1,16'hB004,2'b11,0,1,1, 1,16'h0000,2'b01,1,1, 1,0,1);
    add(0,1,16'hB005,2'b11,1,1,1, 0,16'h0000,2'b00,0,0, 1,0,1);
    add(0,1,16'hC000,2'b11,0,1,1, 1,16'hC000,2'b11,0,0, 0,0,1);
    add(0,1,16'hC001,2'b01,1,1,1, 1,16'hC001,2'b01,1,0, 0,0,1);
    add(0,0,16'h0000,2'b00,0,1,1, 0,16'h0000,2'b00,0,0, 0,0,1);
    // Scenario: link drops after beat 1, terminator once ready, no discard
    add(1,1,16'hD000,2'b11,0,1,1, 1,16'hD000,2'b11,0,0, 0,0,0);
    add(0,0,16'h0000,2'b00,0,0,0, 1,16'hD000,2'b11,0,0, 0,1,1);
    add(0,0,16'h0000,2'b00,0,0,1, 1,16'h0000,2'b01,1,1, 0,0,1);
    add(0,0,16'h0000,2'b00,0,1,1, 0,16'h0000,2'b00,0,0, 0,0,1);
    add(0,1,16'hE000,2'b11,0,1,1, 1,16'hE000,2'b11,0,0, 0,0,1);
    add(0,1,16'hE001,2'b11,1,1,1, 1,16'hE001,2'b11,1,0, 0,0,1);
    add(0,0,16'h0000,2'b00,0,1,1, 0,16'h0000,2'b00,0,0, 0,0,1);
    // Scenario: whole frame arrives with link down
    add(1,1,16'hF000,2'b11,0,0,1, 0,16'h0000,2'b00,0,0, 1,1,1);
    add(0,1,16'hF001,2'b11,1,0,1, 0,16'h0000,2'b00,0,0, 1,0,1);
    add(0,0,16'h0000,2'b00,0,1,1, 0,16'h0000,2'b00,0,0, 0,0,1);
    // Scenario: overflow, stall 4 cycles, new frame starts during CLOSE
    add(1,1,16'h6000,2'b11,0,1,1, 1,16'h6000,2'b11,0,0, 0,0,0);
    add(0,1,16'h6001,2'b11,0,1,0, 1,16'h6000,2'b11,0,0, 1,1,1);
    add(0,1,16'h6002,2'b11,1,1,0, 1,16'h6000,2'b11,0,0, 1,0,1);
    add(0,1,16'h7000,2'b11,0,1,0, 1,16'h6000,2'b11,0,0, 1,0,1);
    add(0,1,16'h7001,2'b11,0,1,0, 1,16'h6000,2'b11,0,0, 1,0,1);
    add(0,1,16'h7002,2'b11,0,1,1, 1,16'h0000,2'b01,1,1, 1,0,1);
    add(0,1,16'h7003,2'b11,1,1,1, 0,16'h0000,2'b00,0,0, 1,0,1);
    add(0,1,16'h8000,2'b11,1,1,1, 1,16'h8000,2'b11,1,0, 0,0,1);
    add(0,0,16'h0000,2'b00,0,1,1, 0,16'h0000,2'b00,0,0, 0,0,1);
    // Scenario: five aborted single-beat frames, counter saturates at 3
    add(1,1,16'h9000,2'b11,1,0,1, 0,16'h0000,2'b00,0,0, 1,1,1);
    add(0,1,16'h9001,2'b11,1,0,1, 0,16'h0000,2'b00,0,0, 1,1,2);
    add(0,1,16'h9002,2'b11,1,0,1, 0,16'h0000,2'b00,0,0, 1,1,3);
    add(0,1,16'h9003,2'b11,1,0,1, 0,16'h0000,2'b00,0,0, 1,1,3);
    add(0,1,16'h9004,2'b11,1,0,1, 0,16'h0000,2'b00,0,0, 1,1,3);
    add(0,0,16'h0000,2'b00,0,1,1, 0,16'h0000,2'b00,0,0, 0,0,3);

    // Reset state
    rst = 1'b1;
    drive(0, '0, '0, 0, 1, 1);
    repeat (2) @(posedge clk);
    #1 check("reset_state", '0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven run through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].rs) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
      drive(vecs[i].v, vecs[i].d, vecs[i].k, vecs[i].l, vecs[i].cu, vecs[i].rdy);
      exp_q.push_back(vecs[i].want);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL vec%0d: scoreboard empty", i);
      end else begin
        check($sformatf("vec%0d", i), exp_q.pop_front());
      end
    end

    // Async reset in the middle of an aborted frame
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    drive(1, 16'h5000, 2'b11, 0, 1, 1);
    @(posedge clk);
    #1 check("mid_first_beat", pack(1, 16'h5000, 2'b11, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(1, 16'h5001, 2'b11, 0, 1, 0);
    @(posedge clk);
    #1 check("mid_overflow", pack(1, 16'h5000, 2'b11, 0, 0, 1, 1, 1));
    #2 rst = 1'b1;
    #1 check("async_reset_now", '0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 16'h5100, 2'b11, 1, 1, 1);
    @(posedge clk);
    #1 check("post_reset_idle", pack(1, 16'h5100, 2'b11, 1, 0, 0, 0, 0));
    @(negedge clk);
    drive(0, '0, '0, 0, 1, 1);
    @(posedge clk);
    #1 check("post_reset_drain", '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
